ofm_pack_bank_writer: RTL
=========================

// Module: ofm_pack_bank_writer
// PURPOSE
//  Parametrised successor of the layer-output save stage. Packs PACK consecutive DATA_W-bit OFM
//  words into one DATA_W*PACK-bit IFM line and writes it round-robin across NUM_BANK buffer banks.
//  Adds start/last framing, a programmable base address, zero-padded partial flush and status.
//  Sits between a layer's OFM output and the next layer's IFM bank buffers.
// PARAMETERS
//  DATA_W   32  width of one OFM word
//  PACK     4   OFM words per packed IFM line (>=2)
//  NUM_BANK 16  IFM banks, written round-robin (>=2)
//  ADDR_W   10  bank address width
//  CNT_W    16  width of the write counter
// PORTS
//  clk         in   1              clock, all logic on rising edge
//  rst         in   1              synchronous, active-high reset
//  i_start     in   1              pulse: load i_base_addr, clear state, begin frame
//  i_base_addr in   ADDR_W         first bank address of the frame
//  i_vld       in   1              i_ofm valid
//  i_last      in   1              qualifies i_vld: final word of frame
//  i_ofm       in   DATA_W         OFM word
//  o_rdy       out  1              word accepted when i_vld & o_rdy
//  o_we        out  1              bank write strobe, one cycle per packed line
//  o_cs        out  NUM_BANK       one-hot bank select, all-zero when o_we=0
//  o_addr      out  ADDR_W         write address shared by all banks
//  o_ifm       out  DATA_W*PACK    packed line; word k at bits [k*DATA_W +: DATA_W]
//  o_busy      out  1              state != IDLE
//  o_done      out  1              one-cycle pulse with the final write of a frame
//  o_wrap      out  1              sticky: address wrapped past 2^ADDR_W-1 this frame
//  o_wr_cnt    out  CNT_W          packed lines written since i_start
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0, lane counter 0, bank index 0, lane and address registers 0.
//  - FSM: IDLE -(i_start)-> RUN -(accept with i_last)-> DRAIN -(1 cycle)-> IDLE.
//  - o_rdy = (state==RUN). Words arriving in IDLE or DRAIN are ignored; no backpressure in RUN.
//  - i_start, from any state: addr<=i_base_addr; bank,lane,o_wr_cnt,o_wrap cleared; lanes zeroed;
//    state<=RUN. An incomplete line is discarded (no write). i_start wins over a same-cycle i_vld.
//  - Accept: i_ofm stored in lane[lane_cnt]; lane_cnt increments, wraps PACK-1 -> 0.
//  - Line write: accepting lane PACK-1 (or any lane with i_last) => next cycle o_we=1,
//    o_cs=1<<bank, o_addr=current addr, o_ifm=lane regs incl. the new word; lanes not yet
//    written in this line are zero. Lane regs clear after every write. Latency 1 cycle.
//  - o_ifm is registered and holds its last written value while o_we=0.
//  - After each write: bank++ ; at bank==NUM_BANK-1 bank<=0 and addr++ (mod 2^ADDR_W);
//    addr wrap to 0 sets o_wrap (held until next i_start or rst). o_wr_cnt++ (wraps silently).
//  - i_last: the line holding it is written in DRAIN with o_done=1 in the same cycle; then IDLE.
//    i_last on lane PACK-1 produces exactly one write (no extra empty line).
//  - Sustained throughput: one word per cycle, one line write every PACK cycles.
//  - rst mid-frame: discards all state, no write, outputs 0 on the next cycle.
// TESTING
//  1 Reset: drive rst 2 cycles -> o_we,o_cs,o_addr,o_ifm,o_busy,o_done,o_wr_cnt all 0, o_rdy=0.
//  2 i_start base=0x010, 4 words 0x11,0x22,0x33,0x44 back-to-back -> 1 cycle after last accept:
//    o_we=1, o_cs=0x0001, o_addr=0x010, o_ifm=0x00000044_00000033_00000022_00000011.
//  3 Stream 64 words (16 lines) -> o_cs walks 0x0001..0x8000, o_addr 0x010 for all; 17th line at
//    o_cs=0x0001, o_addr=0x011; o_wr_cnt=17.
//  4 6 words 1..6, i_last on 6 -> two writes; second o_ifm=0..0_00000006_00000005 (upper lanes 0),
//    o_done=1 with it, then o_busy=0, o_rdy=0.
//  5 base=0x3FF, 17 lines -> 17th line o_addr=0x000, o_wrap=1; new i_start clears o_wrap.
//  6 2 words then i_start (and separately rst) -> no write; next 4 words land at new base, bank 0.

Source files
------------

// File: rtl/ofm_pack_bank_writer.sv
// Packs PACK OFM words into one IFM line and writes the lines round-robin across NUM_BANK banks,
// advancing the shared bank address once every bank has taken a line.
module ofm_pack_bank_writer #(
  parameter int DATA_W   = 32,
  parameter int PACK     = 4,
  parameter int NUM_BANK = 16,
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [ADDR_W-1:0]        i_base_addr,
  input  logic                     i_vld,
  input  logic                     i_last,
  input  logic [DATA_W-1:0]        i_ofm,
  output logic                     o_rdy,
  output logic                     o_we,
  output logic [NUM_BANK-1:0]      o_cs,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [DATA_W*PACK-1:0]   o_ifm,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_wrap,
  output logic [CNT_W-1:0]         o_wr_cnt
);

  localparam int LANE_W = $clog2(PACK);
  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int LINE_W = DATA_W * PACK;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Handshake: a word is taken on a cycle where i_vld & o_rdy and i_start is low.
  // o_rdy depends only on state, so there is no combinational path from inputs to o_rdy.
  state_t              state, state_nxt;
  logic [LANE_W-1:0]   lane_cnt;
  logic [BANK_W-1:0]   bank;
  logic [ADDR_W-1:0]   addr;
  logic [LINE_W-1:0]   lanes;
  logic [LINE_W-1:0]   line_nxt;
  logic                accept;
  logic                line_end;

  assign o_rdy    = (state == S_RUN);
  assign o_busy   = (state != S_IDLE);
  assign accept   = o_rdy & i_vld & ~i_start;
  assign line_end = accept & ((lane_cnt == LANE_W'(PACK - 1)) | i_last);

  // Current lane contents with the incoming word merged in at its lane.
  always_comb begin
    line_nxt = lanes;
    line_nxt[int'(lane_cnt)*DATA_W +: DATA_W] = i_ofm;
  end

  always_comb begin
    state_nxt = state;
    if (i_start) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN:   if (accept && i_last) state_nxt = S_DRAIN;
        S_DRAIN: state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      bank     <= '0;
      addr     <= '0;
      lanes    <= '0;
      o_we     <= 1'b0;
      o_cs     <= '0;
      o_addr   <= '0;
      o_ifm    <= '0;
      o_done   <= 1'b0;
      o_wrap   <= 1'b0;
      o_wr_cnt <= '0;
    end else begin
      o_we   <= 1'b0;
      o_cs   <= '0;
      o_done <= 1'b0;
      if (i_start) begin
        addr     <= i_base_addr;
        bank     <= '0;
        lane_cnt <= '0;
        lanes    <= '0;
        o_wr_cnt <= '0;
        o_wrap   <= 1'b0;
      end else if (line_end) begin
        o_we     <= 1'b1;
        o_cs     <= NUM_BANK'(1) << bank;
        o_addr   <= addr;
        o_ifm    <= line_nxt;
        o_done   <= i_last;
        o_wr_cnt <= o_wr_cnt + CNT_W'(1);
        lanes    <= '0;
        lane_cnt <= '0;
        // All banks hold a line at this address: move to the next row.
        if (bank == BANK_W'(NUM_BANK - 1)) begin
          bank <= '0;
          addr <= addr + ADDR_W'(1);
          if (&addr) o_wrap <= 1'b1;
        end else begin
          bank <= bank + BANK_W'(1);
        end
      end else if (accept) begin
        lanes    <= line_nxt;
        lane_cnt <= lane_cnt + LANE_W'(1);
      end
    end
  end

endmodule
